// File: rtl/bus_memory_if.sv
// rtl/bus_memory_if.sv - CPU external address/data bus between CPU (master) and memory (slave)
interface bus_memory_if;
  logic [63:0] bus_ad;
  logic [7:0]  bus_tag;
  logic        bus_astb;
  logic        bus_rd;
  logic        bus_wr;
  logic [63:0] rd_data;
  logic [7:0]  rd_tag;
  logic        rd_valid;
  logic        err;

  modport master (
    output bus_ad, bus_tag, bus_astb, bus_rd, bus_wr,
    input  rd_data, rd_tag, rd_valid, err
  );

  modport slave (
    input  bus_ad, bus_tag, bus_astb, bus_rd, bus_wr,
    output rd_data, rd_tag, rd_valid, err
  );
endinterface

// File: rtl/bus_memory.sv
// rtl/bus_memory.sv - memory responder: sticky address latch, 72-bit word store, fixed-latency reads
module bus_memory #(
  parameter int AW      = 12,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  bus_memory_if.slave bus
);
  typedef enum logic {IDLE, READ} state_t;

  state_t      state, state_nxt;
  logic [19:0] addr_q, addr_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic [71:0] cap_q, cap_nxt;
  logic [63:0] rd_data_q, rd_data_nxt;
  logic [7:0]  rd_tag_q, rd_tag_nxt;
  logic        rd_valid_q, rd_valid_nxt;
  logic        err_q, err_nxt;
  logic        do_wr;
  logic        in_range;
  logic [71:0] rd_word;

  logic [71:0] mem [2**AW];

  assign in_range = (addr_q >> AW) == 20'd0;
  assign rd_word  = in_range ? mem[addr_q[AW-1:0]] : 72'h0;

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    cnt_nxt      = cnt_q;
    cap_nxt      = cap_q;
    rd_data_nxt  = rd_data_q;
    rd_tag_nxt   = rd_tag_q;
    rd_valid_nxt = 1'b0;
    err_nxt      = err_q;
    do_wr        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.bus_astb) begin
          addr_nxt = bus.bus_ad[19:0];
          if (bus.bus_rd || bus.bus_wr) err_nxt = 1'b1;
        end else if (bus.bus_rd && bus.bus_wr) begin
          err_nxt = 1'b1;
        end else if (bus.bus_wr) begin
          if (in_range) do_wr = 1'b1;
          else          err_nxt = 1'b1;
        end else if (bus.bus_rd) begin
          if (!in_range) err_nxt = 1'b1;
          if (LATENCY == 1) begin
            {rd_tag_nxt, rd_data_nxt} = rd_word;
            rd_valid_nxt = 1'b1;
          end else begin
            cap_nxt   = rd_word;
            cnt_nxt   = 4'(LATENCY - 1);
            state_nxt = READ;
          end
        end
      end
      READ: begin
        if (bus.bus_astb || bus.bus_rd || bus.bus_wr) err_nxt = 1'b1;
        // The edge that takes the counter to zero is the completion edge.
        if (cnt_q == 4'd1) begin
          {rd_tag_nxt, rd_data_nxt} = cap_q;
          rd_valid_nxt = 1'b1;
          cnt_nxt      = 4'd0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_tag_q   <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_q     <= addr_nxt;
      cnt_q      <= cnt_nxt;
      cap_q      <= cap_nxt;
      rd_data_q  <= rd_data_nxt;
      rd_tag_q   <= rd_tag_nxt;
      rd_valid_q <= rd_valid_nxt;
      err_q      <= err_nxt;
    end
  end

  // Store has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (reset && do_wr) mem[addr_q[AW-1:0]] <= {bus.bus_tag, bus.bus_ad};
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_tag   = rd_tag_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_bus_memory.sv
// tb/tb_bus_memory.sv - directed bench driving LATENCY=2/1/4 instances from one shared stimulus
module tb_bus_memory;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] ad = '0;
  logic [7:0]  tag = '0;
  logic        astb = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_memory_if bi2 ();
  bus_memory_if bi1 ();
  bus_memory_if bi4 ();

  assign bi2.bus_ad = ad;  assign bi2.bus_tag = tag;  assign bi2.bus_astb = astb;
  assign bi2.bus_rd = rd;  assign bi2.bus_wr = wr;
  assign bi1.bus_ad = ad;  assign bi1.bus_tag = tag;  assign bi1.bus_astb = astb;
  assign bi1.bus_rd = rd;  assign bi1.bus_wr = wr;
  assign bi4.bus_ad = ad;  assign bi4.bus_tag = tag;  assign bi4.bus_astb = astb;
  assign bi4.bus_rd = rd;  assign bi4.bus_wr = wr;

  bus_memory #(.AW(12), .LATENCY(2)) u2 (.clk(clk), .reset(resetn), .bus(bi2));
  bus_memory #(.AW(12), .LATENCY(1)) u1 (.clk(clk), .reset(resetn), .bus(bi1));
  bus_memory #(.AW(12), .LATENCY(4)) u4 (.clk(clk), .reset(resetn), .bus(bi4));

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  task automatic do_astb(input logic [63:0] a);
    ad = a; astb = 1'b1;
    cyc();
    astb = 1'b0;
  endtask

  task automatic do_wr(input logic [63:0] d, input logic [7:0] t);
    ad = d; tag = t; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  // Issue one rd, then watch each instance for its first rd_valid and pulse count.
  task automatic rd_check(input string nm, input logic [63:0] ed, input logic [7:0] et);
    int f1, f2, f4, n2;
    f1 = 0; f2 = 0; f4 = 0; n2 = 0;
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (bi1.rd_valid && f1 == 0) f1 = k;
      if (bi2.rd_valid) begin n2++; if (f2 == 0) f2 = k; end
      if (bi4.rd_valid && f4 == 0) f4 = k;
      cyc();
    end
    check({nm, "_lat1"}, 64'(f1), 64'd1);
    check({nm, "_lat2"}, 64'(f2), 64'd2);
    check({nm, "_lat4"}, 64'(f4), 64'd4);
    check({nm, "_pulses2"}, 64'(n2), 64'd1);
    check({nm, "_data2"}, bi2.rd_data, ed);
    check({nm, "_tag2"}, 64'(bi2.rd_tag), 64'(et));
    check({nm, "_data1"}, bi1.rd_data, ed);
    check({nm, "_data4"}, bi4.rd_data, ed);
  endtask

  initial begin
    int f2, n;
    do_reset();
    check("rst_data", bi2.rd_data, 64'h0);
    check("rst_tag", 64'(bi2.rd_tag), 64'h0);
    check("rst_valid", 64'(bi2.rd_valid), 64'h0);
    check("rst_err", 64'(bi2.err), 64'h0);

    // Known word at address 0 so the range-error test can show no aliasing write.
    do_astb(64'h0);
    do_wr(64'h0000_0000_0000_AAAA, 8'h11);

    // Basic write then read.
    do_astb(64'hFFFF_FFFF_FFF0_0005);
    do_wr(64'hDEAD_BEEF_0123_4567, 8'h3C);
    rd_check("t1", 64'hDEAD_BEEF_0123_4567, 8'h3C);
    check("t1_err", 64'(bi2.err), 64'h0);

    // Sticky address across writes and reads.
    do_astb(64'h10);
    do_wr(64'h1, 8'h01);
    do_wr(64'h2, 8'h02);
    rd_check("t2a", 64'h2, 8'h02);
    rd_check("t2b", 64'h2, 8'h02);

    // Writes leave the read outputs alone.
    do_wr(64'h77, 8'h77);
    cyc();
    check("t3_hold2", bi2.rd_data, 64'h2);
    check("t3_hold1", bi1.rd_data, 64'h2);
    check("t3_hold4", bi4.rd_data, 64'h2);
    check("t3_err", 64'(bi4.err), 64'h0);

    // Out-of-range address: write dropped, read returns zero.
    do_astb(64'h0_1000);
    do_wr(64'hFF, 8'hEE);
    check("t4_err", 64'(bi2.err), 64'h1);
    rd_check("t4_rd", 64'h0, 8'h00);
    do_astb(64'h0);
    rd_check("t4_alias", 64'h0000_0000_0000_AAAA, 8'h11);

    // Protocol errors.
    do_reset();
    ad = 64'h5; astb = 1'b1; wr = 1'b1;
    cyc();
    astb = 1'b0; wr = 1'b0;
    check("t5_astb_wr", 64'(bi2.err), 64'h1);

    do_reset();
    rd = 1'b1; wr = 1'b1;
    cyc();
    rd = 1'b0; wr = 1'b0;
    check("t5_rd_wr", 64'(bi2.err), 64'h1);
    cyc();
    check("t5_rd_wr_novalid", 64'(bi2.rd_valid), 64'h0);

    do_reset();
    do_astb(64'h5);
    rd = 1'b1;
    cyc();
    rd = 1'b0; ad = 64'h999; tag = 8'h99; wr = 1'b1;
    f2 = 0;
    if (bi2.rd_valid) f2 = 1;
    cyc();
    wr = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      if (bi2.rd_valid && f2 == 0) f2 = k;
      cyc();
    end
    check("t5_inflight_lat", 64'(f2), 64'd2);
    check("t5_inflight_data", bi2.rd_data, 64'hDEAD_BEEF_0123_4567);
    check("t5_inflight_err", 64'(bi2.err), 64'h1);
    check("t5_lat4_err", 64'(bi4.err), 64'h1);
    check("t5_lat4_data", bi4.rd_data, 64'hDEAD_BEEF_0123_4567);

    // Reset during an in-flight read.
    do_reset();
    do_astb(64'h10);
    rd = 1'b1;
    cyc();
    rd = 1'b0; resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (bi2.rd_valid) n++;
      if (bi4.rd_valid) n++;
      cyc();
    end
    check("t6_novalid", 64'(n), 64'd0);
    check("t6_data2", bi2.rd_data, 64'h0);
    check("t6_data4", bi4.rd_data, 64'h0);
    do_astb(64'h10);
    rd_check("t6_after", 64'h77, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
